// File: rtl/flash_req_arbiter.sv
// flash_req_arbiter: round-robin arbiter sharing one flash controller command
// port between NUM_REQ requesters. Each command is sequenced end-to-end:
// latch winner, pulse start, follow the controller busy/ready cycle, then
// return read data with a one-cycle acknowledge to the winner.
// All FSM outputs are registered. A registered output reflects the state that
// was active one cycle earlier. This gives:
//   request -> start = 2 cycles
//   ready rise -> ack = 2 cycles
// Optional watchdog: define FLASH_ARB_TIMEOUT_EN to bound the controller wait
// to TIMEOUT_CYCLES cycles. A timeout completes the command with oERR set.
module flash_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 22,
    parameter int DATA_W         = 8,
    parameter int CMD_W          = 3,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                      iCLK,
    input  logic                      iRST_n,
    input  logic [NUM_REQ-1:0]        iREQ,
    input  logic [NUM_REQ*ADDR_W-1:0] iREQ_ADDR,
    input  logic [NUM_REQ*DATA_W-1:0] iREQ_DATA,
    input  logic [NUM_REQ*CMD_W-1:0]  iREQ_CMD,
    output logic [NUM_REQ-1:0]        oGNT,
    output logic [NUM_REQ-1:0]        oACK,
    output logic [DATA_W-1:0]         oRD_DATA,
    output logic                      oBUSY,
    output logic                      oERR,
    output logic [ADDR_W-1:0]         oFL_ADDR,
    output logic [DATA_W-1:0]         oFL_DATA,
    output logic [CMD_W-1:0]          oFL_CMD,
    output logic                      oFL_Start,
    input  logic [DATA_W-1:0]         iFL_DATA,
    input  logic                      iFL_Ready
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, DONE} state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     rr_q, win_q, rr_d, sel_d;
    logic                 sel_valid_d;
    logic [NUM_REQ-1:0]   gnt_q, ack_q, elig_d, sel_onehot_d;
    logic                 start_q;
    logic [DATA_W-1:0]    rd_data_q, fl_data_q;
    logic [ADDR_W-1:0]    fl_addr_q;
    logic [CMD_W-1:0]     fl_cmd_q;

    logic [ADDR_W-1:0]    req_addr [NUM_REQ];
    logic [DATA_W-1:0]    req_data [NUM_REQ];
    logic [CMD_W-1:0]     req_cmd  [NUM_REQ];

    // Unpack the per-requester fields so the winner can be muxed by index.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_addr[gi] = iREQ_ADDR[gi*ADDR_W +: ADDR_W];
            assign req_data[gi] = iREQ_DATA[gi*DATA_W +: DATA_W];
            assign req_cmd[gi]  = iREQ_CMD[gi*CMD_W +: CMD_W];
        end
    endgenerate

    // The just-acknowledged requester still holds iREQ in its ack cycle;
    // mask it so the same command is not granted twice.
    assign elig_d = iREQ & ~ack_q;

    // Pick the first eligible requester scanning upward from the rr pointer.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        sel_valid_d = 1'b0;
        sel_d       = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = cand[IDX_W-1:0];
            if (!sel_valid_d && elig_d[cand_idx]) begin
                sel_valid_d = 1'b1;
                sel_d       = cand_idx;
            end
        end
    end

    assign sel_onehot_d = NUM_REQ'(1) << sel_d;
    assign rr_d         = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);

`ifdef FLASH_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             timeout_d;
    // The count value in a wait cycle is the number of wait cycles before it.
    assign timeout_d = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign oERR      = err_q;
`else
    logic [31:0] timeout_unused;
    assign timeout_unused = TIMEOUT_CYCLES;
    assign oERR           = 1'b0;
`endif

    // Command sequencer: latch winner, issue, follow ready low/high, acknowledge.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            win_q     <= '0;
            gnt_q     <= '0;
            ack_q     <= '0;
            start_q   <= 1'b0;
            rd_data_q <= '0;
            fl_addr_q <= '0;
            fl_data_q <= '0;
            fl_cmd_q  <= '0;
`ifdef FLASH_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
            ack_q   <= '0;
            case (state_q)
                IDLE: begin
                    if (sel_valid_d && iFL_Ready) begin
                        win_q     <= sel_d;
                        gnt_q     <= sel_onehot_d;
                        fl_addr_q <= req_addr[sel_d];
                        fl_data_q <= req_data[sel_d];
                        fl_cmd_q  <= req_cmd[sel_d];
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    start_q <= 1'b1;
                    state_q <= WAIT_LOW;
`ifdef FLASH_ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                WAIT_LOW: begin
`ifdef FLASH_ARB_TIMEOUT_EN
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (timeout_d) begin
                        rd_data_q <= '0;
                        err_q     <= 1'b1;
                        state_q   <= DONE;
                    end else
`endif
                    if (!iFL_Ready) begin
                        state_q <= WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
`ifdef FLASH_ARB_TIMEOUT_EN
                    cnt_q <= cnt_q + CNT_W'(1);
`endif
                    if (iFL_Ready) begin
                        rd_data_q <= iFL_DATA;
                        state_q   <= DONE;
                    end
`ifdef FLASH_ARB_TIMEOUT_EN
                    else if (timeout_d) begin
                        rd_data_q <= '0;
                        err_q     <= 1'b1;
                        state_q   <= DONE;
                    end
`endif
                end
                DONE: begin
                    ack_q   <= gnt_q;
                    gnt_q   <= '0;
                    rr_q    <= rr_d;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign oGNT      = gnt_q;
    assign oACK      = ack_q;
    assign oRD_DATA  = rd_data_q;
    assign oBUSY     = (state_q != IDLE);
    assign oFL_ADDR  = fl_addr_q;
    assign oFL_DATA  = fl_data_q;
    assign oFL_CMD   = fl_cmd_q;
    assign oFL_Start = start_q;

endmodule

// File: tb/tb_flash_req_arbiter.sv
// tb_flash_req_arbiter: directed bench for flash_req_arbiter. A transaction
// level model predicts every output each cycle. A reactive controller model
// answers start pulses. Compile with FLASH_ARB_TIMEOUT_EN to also exercise the
// watchdog (TIMEOUT_CYCLES = 16).
module tb_flash_req_arbiter;
    localparam int N  = 4;
    localparam int AW = 22;
    localparam int DW = 8;
    localparam int CW = 3;
    localparam int TO = 16;
`ifdef FLASH_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N*CW-1:0] req_cmd = '0;
    logic [DW-1:0]   fl_data = '0;
    logic            fl_ready = 1'b1;
    logic [N-1:0]    gnt, ack;
    logic [DW-1:0]   rd_data, fl_data_o;
    logic [AW-1:0]   fl_addr_o;
    logic [CW-1:0]   fl_cmd_o;
    logic            busy, err, fl_start;

    int n_checks = 0;
    int n_err    = 0;

    flash_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .CMD_W(CW),
                        .TIMEOUT_CYCLES(TO)) dut (
        .iCLK(clk), .iRST_n(rst_n), .iREQ(req), .iREQ_ADDR(req_addr),
        .iREQ_DATA(req_data), .iREQ_CMD(req_cmd), .oGNT(gnt), .oACK(ack),
        .oRD_DATA(rd_data), .oBUSY(busy), .oERR(err), .oFL_ADDR(fl_addr_o),
        .oFL_DATA(fl_data_o), .oFL_CMD(fl_cmd_o), .oFL_Start(fl_start),
        .iFL_DATA(fl_data), .iFL_Ready(fl_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // One command is described by its latch cycle (m_tl) and DONE cycle (m_tf);
    // expected outputs are read off those timestamps.
    bit            m_act = 0, m_fin = 0, m_low = 0, m_err = 0;
    int            m_cyc = 0, m_tl = -10, m_tf = -10, m_win = 0, m_rr = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0, m_rd = '0;
    logic [CW-1:0] m_cmd = '0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_act = 0; m_fin = 0; m_low = 0; m_err = 0;
                m_tl = -10; m_tf = -10; m_win = 0; m_rr = 0;
                m_addr = '0; m_data = '0; m_cmd = '0; m_rd = '0;
            end else begin
                if (m_act) begin
                    if (!m_fin) begin
                        if (m_cyc >= m_tl + 1) begin
                            if (m_low && fl_ready) begin
                                m_fin = 1; m_tf = m_cyc + 1; m_rd = fl_data;
                            end else if (TO_EN && (m_cyc - m_tl == TO)) begin
                                m_fin = 1; m_tf = m_cyc + 1; m_rd = '0; m_err = 1;
                            end else if (!m_low && !fl_ready) begin
                                m_low = 1;
                            end
                        end
                    end else if (m_cyc == m_tf) begin
                        m_act = 0;
                        m_rr  = (m_win + 1) % N;
                    end
                end else begin
                    logic [N-1:0] elig;
                    bit           found;
                    elig  = req;
                    found = 0;
                    if (m_cyc == m_tf + 1) elig[m_win] = 1'b0;
                    if (fl_ready) begin
                        for (int i = 0; i < N; i++) begin
                            if (!found && elig[(m_rr + i) % N]) begin
                                found = 1;
                                m_win = (m_rr + i) % N;
                            end
                        end
                    end
                    if (found) begin
                        m_act = 1; m_fin = 0; m_low = 0; m_tl = m_cyc + 1;
                        m_addr = req_addr[m_win*AW +: AW];
                        m_data = req_data[m_win*DW +: DW];
                        m_cmd  = req_cmd[m_win*CW +: CW];
                    end
                end
                m_cyc++;
            end
        end
    end

    // Compare every DUT output against the model on each falling edge.
    initial begin
        forever begin
            logic [N-1:0] e_gnt, e_ack;
            @(negedge clk);
            e_gnt = m_act ? (N'(1) << m_win) : '0;
            e_ack = (m_cyc == m_tf + 1) ? (N'(1) << m_win) : '0;
            check("cmp_gnt",   gnt, e_gnt);
            check("cmp_ack",   ack, e_ack);
            check("cmp_start", fl_start, (m_act && m_cyc == m_tl + 1));
            check("cmp_busy",  busy, m_act);
            check("cmp_addr",  fl_addr_o, m_addr);
            check("cmp_wdata", fl_data_o, m_data);
            check("cmp_cmd",   fl_cmd_o, m_cmd);
            check("cmp_rdata", rd_data, m_rd);
            check("cmp_err",   err, m_err);
        end
    end

    // ---------------- flash controller model ----------------
    int            ctl_cnt = 0, ctl_low = 5;
    bit            ctl_hang = 0;
    logic [DW-1:0] ctl_data = 8'h00;

    initial begin
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                ctl_cnt = 0;
            end else if (ctl_cnt > 0) begin
                ctl_cnt--;
                if (ctl_cnt == 0 && !ctl_hang) begin
                    fl_ready = 1'b1;
                    fl_data  = ctl_data;
                    ctl_data = ctl_data + 8'h11;
                end
            end else if (fl_start) begin
                fl_ready = 1'b0;
                ctl_cnt  = ctl_low;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk); #2;
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic set_req(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [CW-1:0] c);
        req_addr[k*AW +: AW] = a;
        req_data[k*DW +: DW] = d;
        req_cmd[k*CW +: CW]  = c;
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst_n = 1'b0; fl_ready = 1'b1; ctl_hang = 0; req = '0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    // Wait for n acknowledges, dropping each acknowledged request.
    task automatic serve(input int n, input int budget);
        int got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            tick();
            if (ack != '0) begin
                $display("ack req=%0d cycle=%0d rd_data=%02h", idx_of(ack), m_cyc, rd_data);
                req = req & ~ack;
                got++;
            end
        end
        check("serve_count", got, n);
    endtask

    task automatic wait_gnt(input int budget);
        for (int c = 0; c < budget; c++) begin
            tick();
            if (gnt != '0) return;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation did not finish");
        $fatal(1, "global watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int t0, t_rise, ts, got;
        int rr_seen [8];
        bit prev_rdy;

        tick(); tick();
        check("reset_outputs", {gnt, ack, rd_data, busy, err, fl_addr_o, fl_data_o, fl_cmd_o, fl_start}, 52'h0);
        rst_n = 1'b1;

        // Single read by requester 1.
        set_req(1, 22'h001234, 8'h00, 3'd1);
        ctl_low = 5; ctl_data = 8'hA5;
        tick();
        req = 4'b0010; t0 = m_cyc;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (fl_start) break;
        end
        check("read_start_latency", m_cyc - t0, 2);
        check("read_start_addr", fl_addr_o, 22'h001234);
        prev_rdy = fl_ready; t_rise = -100;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (!prev_rdy && fl_ready && t_rise < 0) t_rise = m_cyc;
            prev_rdy = fl_ready;
            if (ack != '0) break;
        end
        $display("ack req=%0d cycle=%0d rd_data=%02h", idx_of(ack), m_cyc, rd_data);
        check("read_ack", ack, 4'b0010);
        check("read_ack_latency", m_cyc - t_rise, 2);
        check("read_data", rd_data, 8'hA5);
        req = '0;

        // Round robin with all four requesting continuously.
        do_reset();
        for (int k = 0; k < N; k++) set_req(k, AW'(22'h100000 + k * 22'h111), DW'(8'h40 + k), CW'(k));
        ctl_low = 2;
        tick();
        req = 4'b1111; got = 0;
        for (int c = 0; c < 300 && got < 8; c++) begin
            tick();
            if (ack != '0) begin
                rr_seen[got] = idx_of(ack);
                $display("ack req=%0d cycle=%0d rd_data=%02h", rr_seen[got], m_cyc, rd_data);
                got++;
                if (got == 8) req = '0;
            end
        end
        check("rr_count", got, 8);
        for (int i = 0; i < 8; i++) check("rr_order", rr_seen[i], i % 4);

        // Late input change after grant must not disturb the latched address.
        set_req(1, 22'h0ABCDE, 8'h3C, 3'd2);
        ctl_low = 4;
        tick();
        req = 4'b0010;
        wait_gnt(20);
        check("late_gnt", gnt, 4'b0010);
        tick();
        set_req(1, 22'h3FFFFF, 8'hFF, 3'd7);
        for (int c = 0; c < 40; c++) begin
            tick();
            if (ack != '0) break;
            check("late_addr_hold", fl_addr_o, 22'h0ABCDE);
        end
        check("late_ack", ack, 4'b0010);
        req = '0;

        // Reset in WAIT_HIGH; pending requests re-arbitrated from requester 0.
        set_req(0, 22'h000AAA, 8'h11, 3'd1);
        set_req(2, 22'h000CCC, 8'h22, 3'd1);
        ctl_low = 10;
        tick();
        req = 4'b0101;
        wait_gnt(20);
        check("rst_first_gnt", gnt, 4'b0100);
        for (int c = 0; c < 10; c++) begin
            tick();
            if (fl_start) break;
        end
        tick(); tick(); tick();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", {gnt, ack, rd_data, busy, err, fl_addr_o, fl_data_o, fl_cmd_o, fl_start}, 52'h0);
        fl_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        ctl_low = 3;
        wait_gnt(20);
        check("rst_regrant", gnt, 4'b0001);
        serve(2, 80);

        // Controller busy at reset release: grant waits for ready.
        @(posedge clk); #3;
        rst_n = 1'b0; fl_ready = 1'b0; req = 4'b0001;
        set_req(0, 22'h012345, 8'h77, 3'd1);
        tick(); tick();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("notready_no_gnt", gnt, 4'b0000);
        end
        fl_ready = 1'b1;
        tick();
        check("ready_gnt", gnt, 4'b0001);
        check("ready_busy", busy, 1'b1);
        serve(1, 40);

`ifdef FLASH_ARB_TIMEOUT_EN
        // Watchdog: controller never returns to ready.
        ctl_hang = 1; ctl_low = 3;
        set_req(2, 22'h002222, 8'h55, 3'd1);
        tick();
        req = 4'b0100;
        ts = -100;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (fl_start) begin ts = m_cyc; break; end
        end
        for (int c = 0; c < 40; c++) begin
            tick();
            if (ack != '0) break;
        end
        $display("ack req=%0d cycle=%0d rd_data=%02h err=%0b", idx_of(ack), m_cyc, rd_data, err);
        check("to_ack", ack, 4'b0100);
        check("to_ack_latency", m_cyc - ts, 17);
        check("to_err", err, 1'b1);
        check("to_rdata", rd_data, 8'h00);
        req = '0;
        tick(); tick(); tick();
        check("to_err_sticky", err, 1'b1);
        do_reset();
        tick();
        check("to_err_cleared", err, 1'b0);
`else
        ts = 0;
`endif

        tick(); tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
